// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker: buffers packed pixel words in a small FIFO and
// unpacks them into LANES-wide output beats for a counted job started by a PIO edge.
module pixel_stream_unpacker #(
    parameter int WORD_W = 256,
    parameter int PIX_W  = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 24
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic                     cfg_start,
    input  logic [CNT_W-1:0]         cfg_count,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [LANES*PIX_W-1:0]   out_pix,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [31:0]              status_export
);
    localparam int BEAT_W = LANES * PIX_W;
    localparam int BEATS  = WORD_W / BEAT_W;
    localparam int BW     = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int AW     = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic                   start_q, armed, start_pulse;
    logic [WORD_W-1:0]      mem [DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic                   full, empty, wr_en;
    logic                   up_valid;
    logic [WORD_W-1:0]      up_word;
    logic [BEATS-1:0][BEAT_W-1:0] beats_v;
    logic [BW-1:0]          beat;
    logic [CNT_W-1:0]       remaining, take;
    logic [23:0]            emitted;
    logic                   overflow, busy, done, run;
    logic                   accept, last, last_acc, word_end, up_load;

    // armed blocks a start while cfg_start is still high from before reset release
    assign start_pulse = cfg_start & ~start_q & armed;
    assign run         = state == RUN;
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = wr_ptr == rd_ptr;
    assign wr_en       = in_valid & in_ready;
    assign accept      = up_valid & out_ready;
    assign last        = up_valid & (remaining <= CNT_W'(LANES));
    assign last_acc    = accept & last;
    assign word_end    = beat == BW'(BEATS - 1);
    assign up_load     = run & ~empty & (~up_valid | (accept & word_end & ~last));
    assign take        = last ? remaining : CNT_W'(LANES);
    assign beats_v     = up_word;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= cfg_start;
            armed   <= armed | ~cfg_start;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = (!run && start_pulse) ? (cfg_count != '0 ? RUN : DONE) :
                   (run && last_acc)     ? DONE : state;
    end

    always_comb begin
        busy     = run;
        done     = state == DONE;
        in_ready = run & ~full;
    end

    always_ff @(posedge clk_clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= in_data;
    end

    // the final beat's acceptance empties the FIFO in the same cycle
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (last_acc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (up_load)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            up_valid  <= 1'b0;
            up_word   <= '0;
            beat      <= '0;
            remaining <= '0;
            emitted   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (start_pulse && !run) begin
                remaining <= cfg_count;
                emitted   <= '0;
                overflow  <= 1'b0;
            end else begin
                if (run && in_valid && full)
                    overflow <= 1'b1;
                if (accept) begin
                    remaining <= remaining - take;
                    emitted   <= emitted + 24'(take);
                end
            end
            if (up_load) begin
                up_word  <= mem[rd_ptr[AW-1:0]];
                up_valid <= 1'b1;
                beat     <= '0;
            end else if (accept) begin
                up_valid <= ~(last | word_end);
                beat     <= beat + 1'b1;
            end
        end
    end

    // lanes past the remaining count on the final beat are zeroed
    always_comb begin
        out_pix = '0;
        for (int i = 0; i < LANES; i++)
            if (up_valid && CNT_W'(i) < remaining)
                out_pix[i*PIX_W +: PIX_W] = beats_v[beat][i*PIX_W +: PIX_W];
    end

    assign out_valid     = up_valid;
    assign out_last      = last;
    assign status_export = {busy, done, overflow, 5'b0, emitted};
endmodule
